// File: rtl/fa16_rev_ctrl.sv
// fa16_rev_ctrl: synchronous sequencer for the dual-rail reversible 16-bit adder.
// It drives the forward rails, samples the sum/carry/zero rails, checks that the
// backward rails recover the operands, and returns the rails to null. It then
// reports the sampled result and any error class on a valid/ready response port.
//
// state | meaning
// IDLE  | rails null, req_ready high once out of reset, waiting for a request
// FWD   | forward rails valid, settling; sample sum/cout/zero at terminal count
// BWD   | rails held valid; check recovered operands at terminal count
// NULL  | rails driven null; check every input rail is 0 at terminal count
// RSP   | rsp_valid high with a stable result until rsp_ready
module fa16_rev_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NULL_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic        req_cin,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_sum,
    output logic        rsp_cout,
    output logic        rsp_zero,
    output logic [2:0]  rsp_err,
    output logic [15:0] fa_a,
    output logic [15:0] fa_a_not,
    output logic [15:0] fa_b,
    output logic [15:0] fa_b_not,
    output logic        fa_c0_f,
    output logic        fa_c0_f_not,
    input  logic [15:0] fa_s,
    input  logic [15:0] fa_s_not,
    input  logic        fa_c15,
    input  logic        fa_c15_not,
    input  logic        fa_z,
    input  logic        fa_z_not,
    input  logic [15:0] fa_a_b,
    input  logic [15:0] fa_a_not_b,
    input  logic        fa_c0_b,
    input  logic        fa_c0_not_b
);

    localparam int MAX_CYC = (SETTLE_CYCLES > NULL_CYCLES) ? SETTLE_CYCLES : NULL_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] NULL_LD   = CW'(NULL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_BWD,
        S_NULL,
        S_RSP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;

    // The forward rail registers double as the operand latch: while valid they
    // hold a/~a and cin/~cin, which is what the backward check compares against.
    logic [15:0]   a_q, a_d, an_q, an_d, b_q, b_d, bn_q, bn_d;
    logic          c0_q, c0_d, c0n_q, c0n_d;

    logic [15:0]   sum_q, sum_d;
    logic          cout_q, cout_d, zero_q, zero_d;
    logic [2:0]    err_q, err_d;

    logic          fwd_ok, bwd_ok, null_ok;

    assign fwd_ok  = (&(fa_s ^ fa_s_not)) & (fa_c15 ^ fa_c15_not) & (fa_z ^ fa_z_not);
    assign bwd_ok  = (fa_a_b == a_q) && (fa_a_not_b == an_q) &&
                     (fa_c0_b == c0_q) && (fa_c0_not_b == c0n_q);
    assign null_ok = ~|{fa_s, fa_s_not, fa_c15, fa_c15_not, fa_z, fa_z_not,
                        fa_a_b, fa_a_not_b, fa_c0_b, fa_c0_not_b};

    // Next-state, counter, rail and result logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        an_d    = an_q;
        b_d     = b_q;
        bn_d    = bn_q;
        c0_d    = c0_q;
        c0n_d   = c0n_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    a_d     = req_a;
                    an_d    = ~req_a;
                    b_d     = req_b;
                    bn_d    = ~req_b;
                    c0_d    = req_cin;
                    c0n_d   = ~req_cin;
                    err_d   = 3'b000;
                    cnt_d   = SETTLE_LD;
                    state_d = S_FWD;
                end
            end
            S_FWD: begin
                if (cnt_q == '0) begin
                    if (!fwd_ok) err_d[0] = 1'b1;
                    sum_d   = fa_s;
                    cout_d  = fa_c15;
                    zero_d  = fa_z;
                    cnt_d   = SETTLE_LD;
                    state_d = S_BWD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_BWD: begin
                if (cnt_q == '0) begin
                    if (!bwd_ok) err_d[1] = 1'b1;
                    a_d     = '0;
                    an_d    = '0;
                    b_d     = '0;
                    bn_d    = '0;
                    c0_d    = 1'b0;
                    c0n_d   = 1'b0;
                    cnt_d   = NULL_LD;
                    state_d = S_NULL;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_NULL: begin
                if (cnt_q == '0) begin
                    if (!null_ok) err_d[2] = 1'b1;
                    state_d = S_RSP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State, counter, rails and result registers; reset forces the rails null.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            a_q     <= '0;
            an_q    <= '0;
            b_q     <= '0;
            bn_q    <= '0;
            c0_q    <= 1'b0;
            c0n_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            a_q     <= a_d;
            an_q    <= an_d;
            b_q     <= b_d;
            bn_q    <= bn_d;
            c0_q    <= c0_d;
            c0n_q   <= c0n_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = (state_q == S_RSP);
    assign rsp_sum     = sum_q;
    assign rsp_cout    = cout_q;
    assign rsp_zero    = zero_q;
    assign rsp_err     = err_q;
    assign fa_a        = a_q;
    assign fa_a_not    = an_q;
    assign fa_b        = b_q;
    assign fa_b_not    = bn_q;
    assign fa_c0_f     = c0_q;
    assign fa_c0_f_not = c0n_q;

endmodule

// File: tb/tb_fa16_rev_ctrl.sv
// Bench for fa16_rev_ctrl: two instances (default timing and SETTLE=1/NULL=3)
// share the request/response stimulus; each is attached to a behavioural model
// of the reversible adder macro with selectable fault injection.
module tb_fa16_rev_ctrl;

    typedef struct packed {
        logic [15:0] s;
        logic [15:0] s_n;
        logic        c15;
        logic        c15_n;
        logic        z;
        logic        z_n;
        logic [15:0] ab;
        logic [15:0] ab_n;
        logic        c0b;
        logic        c0b_n;
    } mac_t;

    localparam int SETC [2] = '{2, 1};
    localparam int NULC [2] = '{1, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        req_cin = 1'b0;
    int          fault_mode = 0;

    logic [1:0]  req_ready_w, rsp_valid_w, rsp_cout_w, rsp_zero_w;
    logic [1:0]  fa_c0_f_w, fa_c0_f_not_w;
    logic [15:0] rsp_sum_w [2];
    logic [2:0]  rsp_err_w [2];
    logic [15:0] fa_a_w [2];
    logic [15:0] fa_a_not_w [2];
    logic [15:0] fa_b_w [2];
    logic [15:0] fa_b_not_w [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Adder macro: valid rails produce a+b+cin and echo the operands back;
    // null or illegal rails produce null. Modes: 1 breaks s_not[3], 2 flips the
    // recovered a[0], 3 holds z high while the rails are null.
    function automatic mac_t macro_model(input logic [15:0] a, an, b, bn,
                                         input logic c, cn, input int mode);
        mac_t        m;
        logic [16:0] t;
        logic        valid, isnull;
        m      = '0;
        valid  = (a == ~an) && (b == ~bn) && (c == ~cn);
        isnull = (a == 16'h0) && (an == 16'h0) && (b == 16'h0) && (bn == 16'h0) && !c && !cn;
        if (valid) begin
            t       = {1'b0, a} + {1'b0, b} + {16'h0, c};
            m.s     = t[15:0];
            m.s_n   = ~t[15:0];
            m.c15   = t[16];
            m.c15_n = ~t[16];
            m.z     = (t[15:0] == 16'h0);
            m.z_n   = (t[15:0] != 16'h0);
            m.ab    = a;
            m.ab_n  = an;
            m.c0b   = c;
            m.c0b_n = cn;
            if (mode == 2) m.ab[0] = ~m.ab[0];
        end
        if (mode == 1) m.s_n[3] = m.s[3];
        if (mode == 3 && isnull) m.z = 1'b1;
        return m;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mac_t m;

        always_comb m = macro_model(fa_a_w[g], fa_a_not_w[g], fa_b_w[g], fa_b_not_w[g],
                                    fa_c0_f_w[g], fa_c0_f_not_w[g], fault_mode);

        fa16_rev_ctrl #(
            .SETTLE_CYCLES(SETC[g]),
            .NULL_CYCLES  (NULC[g])
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid),
            .req_ready  (req_ready_w[g]),
            .req_a      (req_a),
            .req_b      (req_b),
            .req_cin    (req_cin),
            .rsp_valid  (rsp_valid_w[g]),
            .rsp_ready  (rsp_ready),
            .rsp_sum    (rsp_sum_w[g]),
            .rsp_cout   (rsp_cout_w[g]),
            .rsp_zero   (rsp_zero_w[g]),
            .rsp_err    (rsp_err_w[g]),
            .fa_a       (fa_a_w[g]),
            .fa_a_not   (fa_a_not_w[g]),
            .fa_b       (fa_b_w[g]),
            .fa_b_not   (fa_b_not_w[g]),
            .fa_c0_f    (fa_c0_f_w[g]),
            .fa_c0_f_not(fa_c0_f_not_w[g]),
            .fa_s       (m.s),
            .fa_s_not   (m.s_n),
            .fa_c15     (m.c15),
            .fa_c15_not (m.c15_n),
            .fa_z       (m.z),
            .fa_z_not   (m.z_n),
            .fa_a_b     (m.ab),
            .fa_a_not_b (m.ab_n),
            .fa_c0_b    (m.c0b),
            .fa_c0_not_b(m.c0b_n)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rails_null(input int i);
        return ((fa_a_w[i] | fa_a_not_w[i] | fa_b_w[i] | fa_b_not_w[i]) == 16'h0) &&
               !fa_c0_f_w[i] && !fa_c0_f_not_w[i];
    endfunction

    // One complete request/response; bp = cycles rsp_ready is withheld (0: held high early).
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input int mode, input int bp);
        int          lat, wait_n;
        int          got_lat [2];
        int          ncnt [2];
        logic [15:0] r_sum [2];
        logic        r_cout [2];
        logic        r_zero [2];
        logic [2:0]  r_err [2];
        logic [16:0] full;
        logic [2:0]  exp_err;
        full    = {1'b0, a} + {1'b0, b} + {16'h0, cin};
        exp_err = (mode == 1) ? 3'b001 : (mode == 2) ? 3'b010 : (mode == 3) ? 3'b100 : 3'b000;

        @(negedge clk);
        req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
        fault_mode = mode;
        rsp_ready = (bp == 0);
        wait_n = 0;
        while (req_ready_w != 2'b11 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check("accept_ready", 32'(req_ready_w), 32'h3);
        if (req_ready_w != 2'b11) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Keep a garbage request asserted while busy; it must be ignored.
        req_a = 16'($urandom); req_b = 16'($urandom); req_cin = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            got_lat[i] = -1;
            ncnt[i]    = 0;
            r_sum[i] = '0; r_cout[i] = 1'b0; r_zero[i] = 1'b0; r_err[i] = '0;
            check($sformatf("ready_low[%0d]", i), 32'(req_ready_w[i]), 32'h0);
            check($sformatf("rail_a[%0d]", i), 32'({fa_a_w[i], fa_a_not_w[i]}), 32'({a, ~a}));
            check($sformatf("rail_b[%0d]", i), 32'({fa_b_w[i], fa_b_not_w[i]}), 32'({b, ~b}));
            check($sformatf("rail_c[%0d]", i), 32'({fa_c0_f_w[i], fa_c0_f_not_w[i]}), 32'({cin, ~cin}));
        end
        lat = 0;
        while (lat < 30) begin
            for (int i = 0; i < 2; i++) begin
                if (got_lat[i] < 0) begin
                    if (rsp_valid_w[i]) begin
                        got_lat[i] = lat;
                        r_sum[i]  = rsp_sum_w[i];
                        r_cout[i] = rsp_cout_w[i];
                        r_zero[i] = rsp_zero_w[i];
                        r_err[i]  = rsp_err_w[i];
                    end else if (rails_null(i)) begin
                        ncnt[i]++;
                    end
                end
            end
            if (got_lat[0] >= 0 && got_lat[1] >= 0) break;
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rsp_latency[%0d]", i), 32'(got_lat[i]), 32'(2 * SETC[i] + NULC[i]));
            check($sformatf("null_cycles[%0d]", i), 32'(ncnt[i]), 32'(NULC[i]));
            check($sformatf("sum[%0d]", i), 32'(r_sum[i]), 32'(full[15:0]));
            check($sformatf("cout[%0d]", i), 32'(r_cout[i]), 32'(full[16]));
            check($sformatf("zero[%0d]", i), 32'(r_zero[i]), 32'(full[15:0] == 16'h0));
            check($sformatf("err[%0d]", i), 32'(r_err[i]), 32'(exp_err));
        end
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            req_valid = 1'b1; req_a = 16'($urandom); req_b = 16'($urandom);
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("bp_valid[%0d]", i), 32'(rsp_valid_w[i]), 32'h1);
                check($sformatf("bp_sum[%0d]", i), 32'({rsp_err_w[i], rsp_cout_w[i], rsp_sum_w[i]}),
                      32'({exp_err, full[16], full[15:0]}));
                check($sformatf("bp_ready[%0d]", i), 32'(req_ready_w[i]), 32'h0);
                check($sformatf("bp_null[%0d]", i), 32'(rails_null(i)), 32'h1);
            end
        end
        if (bp > 0) begin
            @(negedge clk);
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("done_valid[%0d]", i), 32'(rsp_valid_w[i]), 32'h0);
            check($sformatf("done_ready[%0d]", i), 32'(req_ready_w[i]), 32'h1);
            check($sformatf("done_null[%0d]", i), 32'(rails_null(i)), 32'h1);
        end
        @(negedge clk);
        rsp_ready  = 1'b0;
        fault_mode = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int v_hits;
        logic [15:0] ra, rb;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_ready[%0d]", i), 32'(req_ready_w[i]), 32'h0);
            check($sformatf("rst_rsp[%0d]", i),
                  32'({rsp_valid_w[i], rsp_cout_w[i], rsp_zero_w[i], rsp_err_w[i], rsp_sum_w[i]}), 32'h0);
            check($sformatf("rst_null[%0d]", i), 32'(rails_null(i)), 32'h1);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_edge", 32'(req_ready_w), 32'h0);
        @(posedge clk); #1;
        check("ready_first_edge", 32'(req_ready_w), 32'h3);

        // Directed cases.
        run_txn(16'h1234, 16'h4321, 1'b0, 0, 0);
        run_txn(16'hFFFF, 16'h0001, 1'b0, 0, 2);
        run_txn(16'hA5A5, 16'h0F0F, 1'b1, 0, 4);
        run_txn(16'h8000, 16'h8000, 1'b1, 0, 4);
        run_txn(16'h00FF, 16'h0101, 1'b0, 1, 0);
        run_txn(16'h7777, 16'h1111, 1'b1, 2, 1);
        run_txn(16'h0000, 16'h0000, 1'b0, 3, 0);

        // Reset in the middle of BWD (default instance).
        @(negedge clk);
        req_a = 16'h2222; req_b = 16'h3333; req_cin = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("midop_rails_live", 32'({fa_a_w[0], fa_a_not_w[0]}), 32'({16'h2222, ~16'h2222}));
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("midop_null[%0d]", i), 32'(rails_null(i)), 32'h1);
            check($sformatf("midop_valid[%0d]", i), 32'(rsp_valid_w[i]), 32'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midop_ready_first_edge", 32'(req_ready_w), 32'h3);
        v_hits = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid_w != 2'b00) v_hits++;
        end
        check("midop_no_rsp", 32'(v_hits), 32'h0);
        run_txn(16'h0001, 16'h0001, 1'b1, 0, 1);

        // Randomized traffic.
        for (int k = 0; k < 30; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (k % 7 == 0) rb = 16'(~ra);
            run_txn(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fa16_rev_ctrl.md
# fa16_rev_ctrl

Sequencing controller that drives the dual-rail reversible 16-bit adder from the synchronous side. It accepts operands over a valid/ready request channel and drives the forward rails (`a`, `b`, `c0_f`, each with its complement). It samples the sum, carry and zero rails, checks that the backward rails (`a_b`, `c0_b`) recover the original operands, and returns all rails to null. It then reports the result and any error class over a valid/ready response channel. It sits between the PE datapath control and the `fa16b_rev` macro.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each of the FWD and BWD phases is held before sampling; must be ≥1.
- `NULL_CYCLES`, default 1: cycles rails are held null before the null check; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  operand request valid.
- `req_ready`  out  1  controller idle and able to accept.
- `req_a`, `req_b`  in  16  operands.
- `req_cin`  in  1  carry in.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_sum`  out  16  sum.
- `rsp_cout`  out  1  carry out.
- `rsp_zero`  out  1  zero flag.
- `rsp_err`  out  3  error flags: [0] forward rail invalid, [1] recovery mismatch, [2] null not reached.
- `fa_a`, `fa_a_not`, `fa_b`, `fa_b_not`  out  16  forward operand rails.
- `fa_c0_f`, `fa_c0_f_not`  out  1  forward carry rails.
- `fa_s`, `fa_s_not`  in  16  sum rails.
- `fa_c15`, `fa_c15_not`  in  1  carry-out rails.
- `fa_z`, `fa_z_not`  in  1  zero rails.
- `fa_a_b`, `fa_a_not_b`  in  16  recovered-operand rails.
- `fa_c0_b`, `fa_c0_not_b`  in  1  recovered-carry rails.

## Operation
- States: IDLE, FWD, BWD, NULL, RSP. A down-counter is sized for max(SETTLE_CYCLES, NULL_CYCLES).
- **Dual-rail encoding:**
  - Null: both rails 0.
  - Valid: rail = value, complement rail = ~value.
  - Rails 1/1 are illegal.
- **IDLE:**
  - `req_ready`=1 and all `fa_*` outputs are null.
  - When `req_valid`&&`req_ready`: latch a, b, cin; clear `rsp_err`; load counter with SETTLE_CYCLES−1; go to FWD.
- **FWD:**
  - Rails are driven valid from latched operands; all `fa_*` outputs are registered.
  - When the counter reaches 0, sample the inputs:
    - `fa_s`/`fa_s_not`, `fa_c15` pair and `fa_z` pair must be exact complements, otherwise set err[0].
    - Latch sum = `fa_s`, cout = `fa_c15`, zero = `fa_z`.
  - Reload the counter and go to BWD.
- **BWD:**
  - Rails are held valid.
  - When the counter reaches 0, require `fa_a_b`==a, `fa_a_not_b`==~a, `fa_c0_b`==cin and `fa_c0_not_b`==~cin, otherwise set err[1].
  - Load NULL_CYCLES−1 and go to NULL.
- **NULL:**
  - All rails are driven 0.
  - When the counter reaches 0, every `fa_*` input bit must be 0, otherwise set err[2].
  - Go to RSP.
- **RSP:**
  - `rsp_valid`=1; `rsp_sum`, `rsp_cout`, `rsp_zero` and `rsp_err` are stable.
  - When `rsp_ready`=1: go to IDLE.
- Error flags do not abort the sequence. The sum is reported as sampled regardless of `rsp_err`.
- No arithmetic is done locally; results come only from the rails.

## Timing
- **Reset:**
  - State is IDLE.
  - All `fa_*` outputs are 0.
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_zero`=0, `rsp_err`=0.
  - `req_ready`=0; it rises on the first edge after `rst` deasserts.
- **Acceptance and phase timing:**
  - On acceptance at edge N, `req_ready` falls and valid rails appear after edge N.
  - FWD occupies SETTLE_CYCLES cycles, BWD SETTLE_CYCLES cycles and NULL NULL_CYCLES cycles.
  - `rsp_valid` rises 2·SETTLE_CYCLES+NULL_CYCLES edges after N (5 with defaults).
- **Response handshake:**
  - `rsp_valid` holds until a `rsp_ready` edge.
  - `req_ready` rises on the edge that completes the response.
  - The next request can be accepted one cycle later. There is no overlap between requests.
- `rsp_ready` held high in advance produces a one-cycle RSP.
- `req_valid` outside IDLE is ignored and the operands are not sampled.
- **Reset mid-operation:**
  - Rails go null asynchronously.
  - The pending result is discarded and no `rsp_valid` is issued.
- A rail pair reading 1/1 or 0/0 during the FWD sample counts as invalid (err[0]).

## Test plan
- **Basic add:** a=0x1234, b=0x4321, cin=0 with a correct adder model → `rsp_sum`=0x5555, cout=0, zero=0, err=000; `rsp_valid` at acceptance+5.
- **Wrap to zero:** a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, zero=1, err=000; all `fa_*` outputs 0 during NULL and after return to IDLE.
- **Back-pressure:** two back-to-back requests with `rsp_ready` held low 4 cycles →
  - first result stable and `req_ready`=0 throughout;
  - the second request is accepted only after the first response completes;
  - the second result is correct.
- **Fault injection:**
  - model forces `fa_s_not[3]`=`fa_s[3]` → err=001;
  - flip `fa_a_b[0]` → err=010;
  - hold `fa_z`=1 in NULL → err=100.
- **Reset mid-operation:** assert `rst` during BWD → `fa_*` outputs 0 in the same cycle, no `rsp_valid`; after release, `req_ready`=1 on the first edge and a=0x0001, b=0x0001, cin=1 yields sum=0x0003.
- **Parameter sweep:** SETTLE_CYCLES=1, NULL_CYCLES=3 → `rsp_valid` at acceptance+5 and `fa_*` outputs null for exactly 3 cycles.
